// File: rtl/retire_stage_pkg.sv
//==============================================================================
// Module : retire_stage_pkg
// Brief  : Shared types and default constants for the in-order retire stage.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package retire_stage_pkg;

    localparam int c_rob_size     = 32;
    localparam int c_xlen         = 32;
    localparam int c_reg_w        = 5;
    localparam int c_flush_cycles = 2;
    localparam int c_cnt_w        = 64;
    localparam int c_tag_w        = $clog2(c_rob_size);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } RT_STATE;

    // Integration bundles at the default widths; bit meaning matches the flat ports.
    typedef struct packed {
        logic               we;
        logic [c_reg_w-1:0] idx;
        logic [c_xlen-1:0]  data;
    } RT_RF_PACKET;

    typedef struct packed {
        logic               clr;
        logic [c_reg_w-1:0] idx;
        logic [c_tag_w-1:0] tag;
    } RT_MT_PACKET;

    typedef struct packed {
        logic              valid;
        logic [c_xlen-1:0] pc;
    } RT_REDIRECT_PACKET;

endpackage

`default_nettype wire

// File: rtl/retire_stage_if.sv
//==============================================================================
// Module : retire_stage_if
// Brief  : ROB-head inputs and commit-side outputs of the retire stage.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface retire_stage_if #(
    parameter int ROB_SIZE = 32,
    parameter int XLEN     = 32,
    parameter int REG_W    = 5,
    parameter int CNT_W    = 64
);
    localparam int TAG_W = $clog2(ROB_SIZE);

    logic             head_valid;
    logic             head_cp;
    logic             head_ep;
    logic             head_halt;
    logic [TAG_W-1:0] head_tag;
    logic [REG_W-1:0] head_reg_idx;
    logic [XLEN-1:0]  head_value;
    logic [XLEN-1:0]  head_npc;

    logic             rt_ack;
    logic             rf_we;
    logic [REG_W-1:0] rf_widx;
    logic [XLEN-1:0]  rf_wdata;
    logic             mt_clr;
    logic [REG_W-1:0] mt_clr_idx;
    logic [TAG_W-1:0] mt_clr_tag;
    logic             squash;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             halted;
    logic [CNT_W-1:0] retired_cnt;

    // ROB / environment side
    modport master (
        output head_valid, head_cp, head_ep, head_halt,
               head_tag, head_reg_idx, head_value, head_npc,
        input  rt_ack, rf_we, rf_widx, rf_wdata, mt_clr, mt_clr_idx, mt_clr_tag,
               squash, redirect_valid, redirect_pc, halted, retired_cnt
    );

    // Retire stage side
    modport slave (
        input  head_valid, head_cp, head_ep, head_halt,
               head_tag, head_reg_idx, head_value, head_npc,
        output rt_ack, rf_we, rf_widx, rf_wdata, mt_clr, mt_clr_idx, mt_clr_tag,
               squash, redirect_valid, redirect_pc, halted, retired_cnt
    );

endinterface

`default_nettype wire

// File: rtl/retire_stage.sv
//==============================================================================
// Module : retire_stage
// Brief  : In-order commit stage: pops the ROB head, writes the ARF, clears the
//          map table, handles branch squash/redirect and halt.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module retire_stage
    import retire_stage_pkg::*;
#(
    parameter int ROB_SIZE     = c_rob_size,
    parameter int XLEN         = c_xlen,
    parameter int REG_W        = c_reg_w,
    parameter int FLUSH_CYCLES = c_flush_cycles,
    parameter int CNT_W        = c_cnt_w
) (
    input  wire logic     clock,
    input  wire logic     reset,
    retire_stage_if.slave bus
);

    localparam int         TAG_W       = $clog2(ROB_SIZE);
    localparam logic [3:0] c_drain_len = 4'(FLUSH_CYCLES);

    RT_STATE          r_state;
    logic [3:0]       r_drain;
    logic             r_rf_we;
    logic [REG_W-1:0] r_rf_widx;
    logic [XLEN-1:0]  r_rf_wdata;
    logic             r_mt_clr;
    logic [REG_W-1:0] r_mt_clr_idx;
    logic [TAG_W-1:0] r_mt_clr_tag;
    logic             r_squash;
    logic             r_redirect_valid;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             r_halted;
    logic [CNT_W-1:0] r_retired_cnt;

    logic             w_retire;
    logic             w_has_dest;

    // Gated by reset so no pop is signalled while the stage is being reset.
    assign w_retire   = !reset && (r_state == RUN) && bus.head_valid && bus.head_cp;
    assign w_has_dest = (bus.head_reg_idx != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= RUN;
            r_drain          <= '0;
            r_rf_we          <= 1'b0;
            r_rf_widx        <= '0;
            r_rf_wdata       <= '0;
            r_mt_clr         <= 1'b0;
            r_mt_clr_idx     <= '0;
            r_mt_clr_tag     <= '0;
            r_squash         <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_halted         <= 1'b0;
            r_retired_cnt    <= '0;
        end else begin
            r_rf_we          <= 1'b0;
            r_mt_clr         <= 1'b0;
            r_squash         <= 1'b0;
            r_redirect_valid <= 1'b0;

            case (r_state)
                RUN: begin
                    if (w_retire) begin
                        r_rf_we       <= w_has_dest;
                        r_rf_widx     <= bus.head_reg_idx;
                        r_rf_wdata    <= bus.head_value;
                        r_mt_clr      <= w_has_dest;
                        r_mt_clr_idx  <= bus.head_reg_idx;
                        r_mt_clr_tag  <= bus.head_tag;
                        r_retired_cnt <= r_retired_cnt + 1'b1;
                        // A taken branch outranks a halt flag on the same entry.
                        if (bus.head_ep) begin
                            r_squash         <= 1'b1;
                            r_redirect_valid <= 1'b1;
                            r_redirect_pc    <= bus.head_npc;
                            r_state          <= SQUASH;
                        end else if (bus.head_halt) begin
                            r_halted <= 1'b1;
                            r_state  <= HALTED;
                        end
                    end
                end
                SQUASH: begin
                    r_drain <= c_drain_len;
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    if (r_drain <= 4'd1) begin
                        r_drain <= '0;
                        r_state <= RUN;
                    end else begin
                        r_drain <= r_drain - 4'd1;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign bus.rt_ack         = w_retire;
    assign bus.rf_we          = r_rf_we;
    assign bus.rf_widx        = r_rf_widx;
    assign bus.rf_wdata       = r_rf_wdata;
    assign bus.mt_clr         = r_mt_clr;
    assign bus.mt_clr_idx     = r_mt_clr_idx;
    assign bus.mt_clr_tag     = r_mt_clr_tag;
    assign bus.squash         = r_squash;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.halted         = r_halted;
    assign bus.retired_cnt    = r_retired_cnt;

endmodule

`default_nettype wire

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- In-order commit stage directly downstream of the ROB.
- Each cycle it inspects the ROB head entry. When the entry is complete, it pops the entry, writes the architectural register file, and clears the matching map-table entry.
- A head entry with its ep bit set (taken branch) triggers a pipeline squash and a fetch redirect, followed by a fixed recovery window.
- A halt instruction retires and then parks the stage until reset.

Parameters:
- ROB_SIZE, 32, ROB entry count; tag width TAG_W = $clog2(ROB_SIZE).
- XLEN, 32, data and PC width.
- REG_W, 5, architectural register index width.
- FLUSH_CYCLES, 2, cycles in DRAIN after a squash (range 1..15).
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- head_valid  in  1  ROB head slot holds an allocated entry
- head_cp  in  1  head entry complete
- head_ep  in  1  head is a taken branch; redirect required
- head_halt  in  1  head is a halt instruction
- head_tag  in  TAG_W  ROB index of the head
- head_reg_idx  in  REG_W  destination register (0 = none)
- head_value  in  XLEN  result value
- head_npc  in  XLEN  redirect target
- rt_ack  out  1  combinational pop of the ROB head, this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_widx  out  REG_W  register-file write index
- rf_wdata  out  XLEN  register-file write data
- mt_clr  out  1  map-table clear request (registered)
- mt_clr_idx  out  REG_W  register to clear
- mt_clr_tag  out  TAG_W  clear only if the map-table tag equals this value
- squash  out  1  one-cycle pipeline flush (registered)
- redirect_valid  out  1  fetch redirect, coincident with squash
- redirect_pc  out  XLEN  fetch target
- halted  out  1  sticky halt indication
- retired_cnt  out  CNT_W  instructions retired since reset

Behaviour:
- Reset (asynchronous, active-high):
  - state = RUN.
  - All registered outputs = 0; retired_cnt = 0; drain counter = 0.
  - rt_ack = 0 while reset is asserted.
  - Reset asserted in any state, including mid-DRAIN or HALTED, returns the stage to RUN next cycle with no pending write.
- States: RUN, SQUASH, DRAIN, HALTED.
- retire condition: state == RUN && head_valid && head_cp.
- rt_ack = retire condition (combinational, zero latency). At most one retire per cycle.
- Registered outputs, cycle T+1 after a retire in cycle T:
  - rf_we = (head_reg_idx != 0); rf_widx = head_reg_idx; rf_wdata = head_value.
  - mt_clr = (head_reg_idx != 0); mt_clr_idx = head_reg_idx; mt_clr_tag = head_tag.
  - retired_cnt increments by 1 (wraps at 2^CNT_W).
  - All write/clear strobes are single-cycle and return to 0 unless another retire occurred in T+1.
- RUN transitions:
  - Retire with head_ep = 1 → SQUASH. In T+1: squash = 1, redirect_valid = 1, redirect_pc = head_npc. The register write from that retire still occurs.
  - Retire with head_halt = 1 (and ep = 0) → HALTED.
  - If ep and halt are both set, ep wins: squash, not halt.
  - Otherwise stay in RUN.
- SQUASH (one cycle; squash is visible):
  - rt_ack = 0.
  - Load the drain counter with FLUSH_CYCLES; go to DRAIN.
- DRAIN:
  - rt_ack = 0.
  - Decrement the counter each cycle; at 1 → RUN.
  - The first retire after a squash therefore happens no earlier than T+2+FLUSH_CYCLES.
- HALTED:
  - halted = 1; rt_ack = 0; no writes. Exit only via reset.
- head_valid = 0 or head_cp = 0 in RUN: no ack, no writes; state holds.
- Tag wrap (index ROB_SIZE-1 followed by 0) needs no special handling; tags are opaque.
- No combinational path from any head_* input to a registered output other than through rt_ack.

Decomposition:
- Shared package (e.g. the existing sys_defs package):
  - RT_STATE enum {RUN, SQUASH, DRAIN, HALTED}.
  - RT_RF_PACKET {we, idx, data}.
  - RT_MT_PACKET {clr, idx, tag}.
  - RT_REDIRECT_PACKET {valid, pc}.
  - FLUSH_CYCLES default constant.
- Ports may be bundled into these packets at integration; bit-level semantics are unchanged.
- No sub-module. Counter and FSM are inline.

Test Plan:
1. Simple retire: head_valid = 1, cp = 1, reg_idx = 5, value = 0xDEADBEEF, tag = 3.
   → rt_ack = 1 same cycle; next cycle rf_we = 1, rf_widx = 5, rf_wdata = 0xDEADBEEF, mt_clr_tag = 3; retired_cnt = 1.
2. No destination: reg_idx = 0, cp = 1.
   → rt_ack = 1; rf_we = 0, mt_clr = 0; retired_cnt still increments.
3. Mispredict: ep = 1, npc = 0x0000_0100, FLUSH_CYCLES = 2, head kept complete afterwards.
   → squash = redirect_valid = 1 at T+1, redirect_pc = 0x100; rt_ack = 0 at T+1..T+3; rt_ack = 1 at T+4.
4. Back-to-back: four complete heads in consecutive cycles (tags 30, 31, 0, 1).
   → rt_ack high four cycles; four consecutive rf writes in order; retired_cnt = 4.
5. Halt then stimulus: halt retires at T.
   → halted = 1 from T+1; later complete heads give rt_ack = 0. Asynchronous reset mid-cycle → halted = 0 immediately, RUN resumes.
6. Reset during DRAIN: assert reset one cycle after squash.
   → all outputs 0 at once; the first complete head after deassertion is acked with no drain delay.
